// File: rtl/sd_frame_loader.sv
// sd_frame_loader: streams a packed 12-bit RGB frame from the SD card into the
// frame buffer. It issues block reads, takes one byte per rising edge of the
// byte strobe, and unpacks each 3-byte group into 2 pixels written sequentially.
//
// Ports:
//   clk_25mhz          system clock
//   reset              asynchronous active-low reset
//   start              one-cycle pulse, begins a frame load (IDLE/DONE only)
//   sd_ready           sd_controller ready for a command
//   sd_byte_available  sd_controller byte strobe (level, may stay high)
//   sd_dout[7:0]       sd_controller read byte
//   sd_rd              read request to sd_controller
//   sd_addr[31:0]      byte address of the current block
//   mem_we             frame buffer write enable (single-cycle pulse)
//   mem_addr[18:0]     frame buffer write address
//   mem_din[11:0]      frame buffer write data
//   busy               high from accepted start until done
//   done               high (held) after the last pixel is written
module sd_frame_loader #(
   parameter int unsigned NUM_PIXELS  = 307200,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned BLOCK_BYTES = 512
) (
   input  logic        clk_25mhz,
   input  logic        reset,
   input  logic        start,
   input  logic        sd_ready,
   input  logic        sd_byte_available,
   input  logic [7:0]  sd_dout,
   output logic        sd_rd,
   output logic [31:0] sd_addr,
   output logic        mem_we,
   output logic [18:0] mem_addr,
   output logic [11:0] mem_din,
   output logic        busy,
   output logic        done
);

   localparam int unsigned PCW = 19;
   localparam int unsigned BCW = $clog2(BLOCK_BYTES) + 1;

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_READY = 3'd1;
   localparam logic [2:0] S_ISSUE      = 3'd2;
   localparam logic [2:0] S_READ       = 3'd3;
   localparam logic [2:0] S_DONE       = 3'd4;

   logic [2:0]     state_q,      state_d;
   logic           sd_rd_q,      sd_rd_d;
   logic [31:0]    sd_addr_q,    sd_addr_d;
   logic           mem_we_q,     mem_we_d;
   logic [18:0]    mem_addr_q,   mem_addr_d;
   logic [11:0]    mem_din_q,    mem_din_d;
   logic           busy_q,       busy_d;
   logic           done_q,       done_d;
   logic [PCW-1:0] pix_cnt_q,    pix_cnt_d;
   logic [BCW-1:0] byte_cnt_q,   byte_cnt_d;
   logic [1:0]     phase_q,      phase_d;
   logic [7:0]     byte0_q,      byte0_d;
   logic [3:0]     nib_q,        nib_d;
   logic           avail_prev_q, avail_prev_d;

   logic           byte_edge;
   logic [PCW-1:0] pix_next;
   logic [BCW-1:0] byte_cnt_inc;
   logic           pix_room;

   // Strobe edge is tracked continuously, so a strobe already high on READ
   // entry is only counted after it drops and rises again.
   assign byte_edge    = sd_byte_available & ~avail_prev_q;
   assign byte_cnt_inc = byte_cnt_q + BCW'(1);
   assign pix_room     = (pix_cnt_q < PCW'(NUM_PIXELS));

   // Next-state, counters and registered outputs.
   always_comb begin
      state_d      = state_q;
      sd_rd_d      = sd_rd_q;
      sd_addr_d    = sd_addr_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pix_cnt_d    = pix_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      phase_d      = phase_q;
      byte0_d      = byte0_q;
      nib_d        = nib_q;
      avail_prev_d = sd_byte_available;
      pix_next     = pix_cnt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
            if (start) begin
               done_d     = 1'b0;
               busy_d     = 1'b1;
               pix_cnt_d  = '0;
               byte_cnt_d = '0;
               phase_d    = '0;
               mem_addr_d = '0;
               sd_addr_d  = 32'(BASE_ADDR);
               state_d    = S_WAIT_READY;
            end
         end

         S_WAIT_READY: begin
            if (sd_ready) begin
               sd_rd_d = 1'b1;
               state_d = S_ISSUE;
            end
         end

         // Hold the request until the controller takes it (ready drops).
         S_ISSUE: begin
            if (!sd_ready) begin
               sd_rd_d = 1'b0;
               state_d = S_READ;
            end else begin
               sd_rd_d = 1'b1;
            end
         end

         S_READ: begin
            if (byte_edge) begin
               case (phase_q)
                  2'd0: begin
                     byte0_d = sd_dout;
                     phase_d = 2'd1;
                  end
                  2'd1: begin
                     nib_d   = sd_dout[3:0];
                     phase_d = 2'd2;
                     if (pix_room) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = pix_cnt_q;
                        mem_din_d  = {byte0_q, sd_dout[7:4]};
                        pix_next   = pix_cnt_q + PCW'(1);
                     end
                  end
                  default: begin
                     phase_d = 2'd0;
                     if (pix_room) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = pix_cnt_q;
                        mem_din_d  = {nib_q, sd_dout};
                        pix_next   = pix_cnt_q + PCW'(1);
                     end
                  end
               endcase
               pix_cnt_d = pix_next;

               // Block end: advance the SD address; phase carries over.
               if (byte_cnt_inc == BCW'(BLOCK_BYTES)) begin
                  byte_cnt_d = '0;
                  sd_addr_d  = sd_addr_q + 32'(BLOCK_BYTES);
                  state_d    = (pix_next < PCW'(NUM_PIXELS)) ? S_WAIT_READY : S_DONE;
               end else begin
                  byte_cnt_d = byte_cnt_inc;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_25mhz or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         sd_rd_q      <= 1'b0;
         sd_addr_q    <= 32'(BASE_ADDR);
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pix_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         phase_q      <= '0;
         byte0_q      <= '0;
         nib_q        <= '0;
         avail_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sd_rd_q      <= sd_rd_d;
         sd_addr_q    <= sd_addr_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pix_cnt_q    <= pix_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         phase_q      <= phase_d;
         byte0_q      <= byte0_d;
         nib_q        <= nib_d;
         avail_prev_q <= avail_prev_d;
      end
   end

   assign sd_rd    = sd_rd_q;
   assign sd_addr  = sd_addr_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_sd_frame_loader.sv
// Bench for sd_frame_loader: small frame (10 pixels, 4-byte blocks) so pixels
// straddle blocks and the last block carries a pad byte. A behavioural SD
// model serves random byte streams; expected pixels come from the 3-byte ->
// 2-pixel packing rule applied directly to the stream.
module tb_sd_frame_loader;

   localparam int unsigned NP   = 10;
   localparam int unsigned BB   = 4;
   localparam int unsigned BASE = 32'h200;
   localparam int NBYTES = NP * 3 / 2;
   localparam int NBLK   = (NBYTES + BB - 1) / BB;
   localparam int TOT    = NBLK * BB;

   logic        clk_25mhz = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        sd_ready = 1'b1;
   logic        sd_byte_available = 1'b0;
   logic [7:0]  sd_dout = 8'h00;
   logic        sd_rd;
   logic [31:0] sd_addr;
   logic        mem_we;
   logic [18:0] mem_addr;
   logic [11:0] mem_din;
   logic        busy;
   logic        done;

   sd_frame_loader #(
      .NUM_PIXELS (NP),
      .BASE_ADDR  (BASE),
      .BLOCK_BYTES(BB)
   ) dut (
      .clk_25mhz        (clk_25mhz),
      .reset            (reset),
      .start            (start),
      .sd_ready         (sd_ready),
      .sd_byte_available(sd_byte_available),
      .sd_dout          (sd_dout),
      .sd_rd            (sd_rd),
      .sd_addr          (sd_addr),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_din          (mem_din),
      .busy             (busy),
      .done             (done)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   int errors = 0;
   int checks = 0;

   logic [7:0]  stream [TOT];
   logic [18:0] wr_addr_q [$];
   logic [11:0] wr_data_q [$];
   logic [31:0] rd_addr_q [$];
   logic        rd_prev = 1'b0;

   // Record every write pulse and every new read request.
   always @(negedge clk_25mhz) begin
      if (reset) begin
         if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_din);
         end
         if (sd_rd && !rd_prev) rd_addr_q.push_back(sd_addr);
      end
      rd_prev = sd_rd;
   end

   // Reference: pixel i from bytes of group i/2.
   function automatic logic [11:0] exp_pix(input int i);
      int k;
      logic [7:0] b0, b1, b2;
      k  = (i / 2) * 3;
      b0 = stream[k];
      b1 = stream[k+1];
      b2 = stream[k+2];
      if (i % 2 == 0) return {b0, b1[7:4]};
      return {b1[3:0], b2};
   endfunction

   function automatic int first_bad_write();
      if (wr_addr_q.size() != NP) return -2;
      for (int i = 0; i < NP; i++)
         if (wr_addr_q[i] !== 19'(i) || wr_data_q[i] !== exp_pix(i)) return i;
      return -1;
   endfunction

   function automatic int first_bad_read();
      if (rd_addr_q.size() != NBLK) return -2;
      for (int i = 0; i < NBLK; i++)
         if (rd_addr_q[i] !== BASE + 32'(i) * BB) return i;
      return -1;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < TOT; i++) stream[i] = 8'($urandom);
   endtask

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
   endtask

   task automatic pulse_start();
      @(negedge clk_25mhz);
      start = 1'b1;
      @(negedge clk_25mhz);
      start = 1'b0;
   endtask

   // SD controller model: serves NBLK blocks of the stream. Optional start
   // pulse after byte mid_start, optional async reset while byte abort_at
   // is on the strobe.
   task automatic serve(input int wmax, input int gmax, input bit pre_high,
                        input int mid_start, input int abort_at, output bit aborted);
      int idx;
      int t;
      aborted = 1'b0;
      idx = 0;
      for (int blk = 0; blk < NBLK; blk++) begin
         t = 0;
         while (sd_rd !== 1'b1 && t < 300) begin
            @(negedge clk_25mhz);
            t++;
         end
         checks++;
         if (t >= 300) begin
            errors++;
            $display("FAIL rd_timeout block=%0d sd_rd=%b expected 1", blk, sd_rd);
            return;
         end
         repeat ($urandom_range(0, 2)) @(negedge clk_25mhz);
         checks++;
         if (sd_rd !== 1'b1) begin
            errors++;
            $display("FAIL rd_hold block=%0d sd_rd=%b expected 1", blk, sd_rd);
         end
         if (pre_high && blk == 0) begin
            sd_dout = 8'hFF;
            sd_byte_available = 1'b1;
         end
         sd_ready = 1'b0;
         @(negedge clk_25mhz);
         checks++;
         if (sd_rd !== 1'b0) begin
            errors++;
            $display("FAIL rd_drop block=%0d sd_rd=%b expected 0", blk, sd_rd);
         end
         if (pre_high && blk == 0) begin
            repeat (2) @(negedge clk_25mhz);
            sd_byte_available = 1'b0;
            @(negedge clk_25mhz);
         end
         for (int k = 0; k < BB; k++) begin
            sd_dout = stream[idx];
            sd_byte_available = 1'b1;
            @(negedge clk_25mhz);
            if (idx == abort_at) begin
               #5;
               reset = 1'b0;
               #1;
               checks++;
               if (sd_rd !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                   sd_addr !== BASE) begin
                  errors++;
                  $display("FAIL async_reset rd=%b we=%b busy=%b done=%b addr=%h expected 0 0 0 0 %h",
                           sd_rd, mem_we, busy, done, sd_addr, BASE);
               end
               sd_byte_available = 1'b0;
               sd_ready = 1'b1;
               aborted = 1'b1;
               return;
            end
            repeat ($urandom_range(1, wmax) - 1) @(negedge clk_25mhz);
            sd_byte_available = 1'b0;
            repeat ($urandom_range(1, gmax)) @(negedge clk_25mhz);
            idx++;
            if (idx == mid_start) begin
               start = 1'b1;
               @(negedge clk_25mhz);
               start = 1'b0;
            end
         end
         sd_ready = 1'b1;
      end
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (done !== 1'b1 && t < 300) begin
         @(negedge clk_25mhz);
         t++;
      end
      checks++;
      if (t >= 300) begin
         errors++;
         $display("FAIL %s done_timeout done=%b expected 1", name, done);
      end
      @(negedge clk_25mhz);
   endtask

   task automatic test_reset();
      checks++;
      if (sd_rd !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          mem_addr !== 19'd0 || mem_din !== 12'd0 || sd_addr !== BASE) begin
         errors++;
         $display("FAIL reset_state rd=%b we=%b busy=%b done=%b maddr=%h din=%h sd_addr=%h expected all zero, sd_addr=%h",
                  sd_rd, mem_we, busy, done, mem_addr, mem_din, sd_addr, BASE);
      end
   endtask

   task automatic test_basic_unpack();
      bit ab;
      int r;
      fill_random();
      stream[0] = 8'hAB; stream[1] = 8'hCD; stream[2] = 8'hEF;
      stream[3] = 8'h12; stream[4] = 8'h34; stream[5] = 8'h56;
      clear_mon();
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy busy=%b expected 1", busy);
      end
      serve(1, 1, 1'b0, -1, -1, ab);
      wait_done("basic");
      r = first_bad_write();
      checks++;
      if (r != -1) begin
         errors++;
         $display("FAIL basic_writes first_bad=%0d count=%0d expected all %0d correct", r, wr_addr_q.size(), NP);
      end
      checks++;
      if (wr_data_q.size() < 4 || wr_data_q[0] !== 12'hABC || wr_data_q[1] !== 12'hDEF ||
          wr_data_q[2] !== 12'h123 || wr_data_q[3] !== 12'h456) begin
         errors++;
         $display("FAIL basic_known_pixels got size %0d expected ABC DEF 123 456", wr_data_q.size());
      end
      r = first_bad_read();
      checks++;
      if (r != -1) begin
         errors++;
         $display("FAIL basic_reads first_bad=%0d count=%0d expected %0d reads from %h", r, rd_addr_q.size(), NBLK, BASE);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || mem_addr !== 19'(NP - 1) || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL basic_done done=%b busy=%b maddr=%0d we=%b expected 1 0 %0d 0", done, busy, mem_addr, mem_we, NP - 1);
      end
   endtask

   task automatic test_strobe_width();
      bit ab;
      int r;
      fill_random();
      clear_mon();
      pulse_start();
      serve(4, 3, 1'b1, -1, -1, ab);
      wait_done("strobe");
      r = first_bad_write();
      checks++;
      if (r != -1) begin
         errors++;
         $display("FAIL strobe_writes first_bad=%0d count=%0d expected %0d correct writes", r, wr_addr_q.size(), NP);
      end
      r = first_bad_read();
      checks++;
      if (r != -1) begin
         errors++;
         $display("FAIL strobe_reads first_bad=%0d count=%0d expected %0d", r, rd_addr_q.size(), NBLK);
      end
   endtask

   task automatic test_handshake();
      bit ab;
      bit bad;
      int r;
      fill_random();
      clear_mon();
      sd_ready = 1'b0;
      pulse_start();
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_25mhz);
         if (sd_rd !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL hs_no_rd sd_rd went high while sd_ready=0, expected 0");
      end
      sd_ready = 1'b1;
      repeat (2) @(negedge clk_25mhz);
      checks++;
      if (sd_rd !== 1'b1) begin
         errors++;
         $display("FAIL hs_rd_rise sd_rd=%b expected 1", sd_rd);
      end
      serve(2, 2, 1'b0, -1, -1, ab);
      wait_done("handshake");
      r = first_bad_write();
      checks++;
      if (r != -1) begin
         errors++;
         $display("FAIL hs_writes first_bad=%0d expected -1", r);
      end
   endtask

   task automatic test_start_gating();
      bit ab;
      int r;
      fill_random();
      clear_mon();
      pulse_start();
      serve(2, 2, 1'b0, 5, -1, ab);
      wait_done("gating");
      r = first_bad_write();
      checks++;
      if (r != -1) begin
         errors++;
         $display("FAIL gate_busy_start first_bad=%0d count=%0d expected %0d untouched writes", r, wr_addr_q.size(), NP);
      end
      r = first_bad_read();
      checks++;
      if (r != -1) begin
         errors++;
         $display("FAIL gate_reads first_bad=%0d count=%0d expected %0d", r, rd_addr_q.size(), NBLK);
      end
      fill_random();
      clear_mon();
      pulse_start();
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL gate_restart done=%b busy=%b expected 0 1", done, busy);
      end
      serve(1, 2, 1'b0, -1, -1, ab);
      wait_done("restart");
      checks++;
      if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 19'd0) begin
         errors++;
         $display("FAIL gate_first_addr count=%0d expected first write at 0", wr_addr_q.size());
      end
      r = first_bad_write();
      checks++;
      if (r != -1) begin
         errors++;
         $display("FAIL gate_restart_writes first_bad=%0d expected -1", r);
      end
   endtask

   task automatic test_async_reset();
      bit ab;
      int r;
      fill_random();
      clear_mon();
      pulse_start();
      serve(3, 2, 1'b0, -1, 4, ab);
      repeat (2) @(negedge clk_25mhz);
      reset = 1'b1;
      fill_random();
      clear_mon();
      pulse_start();
      serve(2, 2, 1'b0, -1, -1, ab);
      wait_done("post_reset");
      checks++;
      if (rd_addr_q.size() == 0 || rd_addr_q[0] !== BASE) begin
         errors++;
         $display("FAIL reset_restart_addr count=%0d expected first read at %h", rd_addr_q.size(), BASE);
      end
      r = first_bad_write();
      checks++;
      if (r != -1) begin
         errors++;
         $display("FAIL reset_restart_writes first_bad=%0d expected -1", r);
      end
   endtask

   task automatic test_back_to_back();
      bit ab;
      int r;
      for (int n = 0; n < 3; n++) begin
         fill_random();
         clear_mon();
         pulse_start();
         serve(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), -1, -1, ab);
         wait_done("b2b");
         r = first_bad_write();
         checks++;
         if (r != -1) begin
            errors++;
            $display("FAIL b2b_writes load=%0d first_bad=%0d count=%0d expected %0d", n, r, wr_addr_q.size(), NP);
         end
         r = first_bad_read();
         checks++;
         if (r != -1) begin
            errors++;
            $display("FAIL b2b_reads load=%0d first_bad=%0d expected -1", n, r);
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk_25mhz);
      test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk_25mhz);
      test_basic_unpack();
      test_strobe_width();
      test_handshake();
      test_start_gating();
      test_async_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
